seq_mult_stream: RTL and testbench

Parametrised digit-serial multiplier. It takes two operands of a runtime-selectable width (1..MAX_WIDTH/P digits of P bits each) in signed or unsigned mode and streams the full double-width product out LSB-first, one P-bit digit per handshake. It is the generalised successor of the fixed P=2 sequential multiplier. It adds arbitrary P, a per-operation signed/unsigned mode, output backpressure and an explicit last-digit flag. It sits between the operand-fetch stage (valid/ready in) and the bit-serial accumulate/writeback stage (valid/ready out).

---
 rtl/seq_mult_stream.sv | 204 ++++++++++++++++++++
 tb/tb_seq_mult_stream.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_stream.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// seq_mult_stream
//
// Digit-serial multiplier. It multiplies two operands of n P-bit digits, where
// n is chosen per operation. Operands are signed or unsigned, also chosen per
// operation. The full 2n-digit product is streamed out LSB-first, one P-bit
// digit per output handshake. It uses product scanning: one a_i*b_j term is
// accumulated per cycle. Column k collects all terms with i+j == k.
//
// Ports
//   clk            clock
//   rst_n          asynchronous active-low reset
//   a_i, b_i       operands (low n*P bits used), latched at accept
//   n_digits_i     operand width in digits (0 or > D means D)
//   signed_i       1 = two's-complement operands
//   valid_i        operand valid
//   ready_o        high in IDLE; accept = valid_i & ready_o
//   digit_o        current product digit (registered)
//   digit_valid_o  digit_o valid (registered state decode)
//   digit_ready_i  downstream accepts digit
//   digit_last_o   digit_o is product digit 2n-1
//   busy_o         operation in progress
// -----------------------------------------------------------------------------
module seq_mult_stream #(
  parameter int P         = 2,
  parameter int MAX_WIDTH = 16,
  localparam int D        = MAX_WIDTH / P,
  localparam int NW       = $clog2(D) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [MAX_WIDTH-1:0] a_i,
  input  logic [MAX_WIDTH-1:0] b_i,
  input  logic [NW-1:0]        n_digits_i,
  input  logic                 signed_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [P-1:0]         digit_o,
  output logic                 digit_valid_o,
  input  logic                 digit_ready_i,
  output logic                 digit_last_o,
  output logic                 busy_o
);

  localparam int CW = NW + 1;         // column index reaches 2D-1
  localparam int PW = 2 * P + 2;      // (P+1)x(P+1) signed digit product
  localparam int AW = 2 * P + NW + 1; // column accumulator

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_EMIT} state_t;

  state_t                r_state, w_state_next;
  logic [MAX_WIDTH-1:0]  r_a, r_b;
  logic                  r_signed;
  logic [NW-1:0]         r_n;
  logic [CW-1:0]         r_col;
  logic [NW-1:0]         r_term;
  logic signed [AW-1:0]  r_acc;
  logic [P-1:0]          r_digit;
  logic                  r_last;

  logic [NW-1:0]         w_n_eff;
  logic [CW-1:0]         w_n_ext, w_nm1, w_last_col;
  logic [CW-1:0]         w_i_lo, w_i_hi, w_i, w_j, w_col_inc;
  logic                  w_term_last, w_inc_empty, w_is_last_col;
  logic [P-1:0]          w_a_digs [D];
  logic [P-1:0]          w_b_digs [D];
  logic [P-1:0]          w_a_dig, w_b_dig;
  logic [P:0]            w_a_ext, w_b_ext;
  logic signed [PW-1:0]  w_a_se, w_b_se, w_prod;
  logic signed [AW-1:0]  w_term, w_sum;

  // Zero or oversized digit counts both mean "full width".
  assign w_n_eff = (n_digits_i == '0 || n_digits_i > NW'(D)) ? NW'(D) : n_digits_i;

  // Column bookkeeping: i runs from max(0, k-(n-1)) to min(k, n-1).
  assign w_n_ext       = {1'b0, r_n};
  assign w_nm1         = w_n_ext - CW'(1);
  assign w_last_col    = (w_n_ext << 1) - CW'(1);
  assign w_i_lo        = (r_col > w_nm1) ? (r_col - w_nm1) : '0;
  assign w_i_hi        = (r_col < w_nm1) ? r_col : w_nm1;
  assign w_i           = w_i_lo + {1'b0, r_term};
  assign w_j           = r_col - w_i;
  assign w_term_last   = (w_i == w_i_hi);
  assign w_col_inc     = r_col + CW'(1);
  // Only the top column (2n-1) has no terms.
  assign w_inc_empty   = (w_col_inc == w_last_col);
  assign w_is_last_col = (r_col == w_last_col);

  // Split operands into digit arrays, then select digits i and j by mux.
  for (genvar gi = 0; gi < D; gi++) begin : g_digs
    assign w_a_digs[gi] = r_a[gi*P +: P];
    assign w_b_digs[gi] = r_b[gi*P +: P];
  end

  always_comb begin
    w_a_dig = '0;
    w_b_dig = '0;
    for (int k = 0; k < D; k++) begin
      if (w_i == CW'(k)) w_a_dig = w_a_digs[k];
      if (w_j == CW'(k)) w_b_dig = w_b_digs[k];
    end
  end

  // The top digit of a signed operand carries the sign. All lower digits are
  // unsigned. So each digit becomes a (P+1)-bit signed value.
  assign w_a_ext = {r_signed & (w_i == w_nm1) & w_a_dig[P-1], w_a_dig};
  assign w_b_ext = {r_signed & (w_j == w_nm1) & w_b_dig[P-1], w_b_dig};
  assign w_a_se  = {{(PW-P-1){w_a_ext[P]}}, w_a_ext};
  assign w_b_se  = {{(PW-P-1){w_b_ext[P]}}, w_b_ext};
  assign w_prod  = w_a_se * w_b_se;
  assign w_term  = {{(AW-PW){w_prod[PW-1]}}, w_prod};
  assign w_sum   = r_acc + w_term;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (valid_i) w_state_next = S_MAC;
      S_MAC:  if (w_term_last) w_state_next = S_EMIT;
      S_EMIT: begin
        if (digit_ready_i) begin
          if (w_is_last_col)    w_state_next = S_IDLE;
          else if (w_inc_empty) w_state_next = S_EMIT;
          else                  w_state_next = S_MAC;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM: outputs (decoded from registered state only)
  always_comb begin
    ready_o       = (r_state == S_IDLE);
    busy_o        = (r_state != S_IDLE);
    digit_valid_o = (r_state == S_EMIT);
    digit_o       = r_digit;
    digit_last_o  = r_last;
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_n      <= '0;
      r_col    <= '0;
      r_term   <= '0;
      r_acc    <= '0;
      r_digit  <= '0;
      r_last   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (valid_i) begin
            r_a      <= a_i;
            r_b      <= b_i;
            r_signed <= signed_i;
            r_n      <= w_n_eff;
            r_col    <= '0;
            r_term   <= '0;
            r_acc    <= '0;
          end
        end
        S_MAC: begin
          if (w_term_last) begin
            r_digit <= w_sum[P-1:0];
            r_acc   <= w_sum >>> P;
            r_last  <= w_is_last_col;
            r_term  <= '0;
          end else begin
            r_acc  <= w_sum;
            r_term <= r_term + NW'(1);
          end
        end
        S_EMIT: begin
          // While digit_ready_i is low, everything holds.
          if (digit_ready_i) begin
            if (w_is_last_col) begin
              r_last <= 1'b0;
            end else begin
              r_col <= w_col_inc;
              if (w_inc_empty) begin
                // The empty top column is just the remaining carry.
                r_digit <= r_acc[P-1:0];
                r_acc   <= r_acc >>> P;
                r_last  <= 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_stream.sv
`timescale 1ns/1ps
module tb_seq_mult_stream;
  localparam int P  = 2;
  localparam int MW = 16;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [MW-1:0] a_i = '0, b_i = '0;
  logic [NW-1:0] n_digits_i = '0;
  logic          signed_i = 1'b0, valid_i = 1'b0, digit_ready_i = 1'b1;
  logic          ready_o, digit_valid_o, digit_last_o, busy_o;
  logic [P-1:0]  digit_o;

  seq_mult_stream #(.P(P), .MAX_WIDTH(MW)) dut (
    .clk(clk), .rst_n(rst_n), .a_i(a_i), .b_i(b_i), .n_digits_i(n_digits_i),
    .signed_i(signed_i), .valid_i(valid_i), .ready_o(ready_o),
    .digit_o(digit_o), .digit_valid_o(digit_valid_o),
    .digit_ready_i(digit_ready_i), .digit_last_o(digit_last_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0, n_err = 0;
  logic [2:0] q[$];          // {last, digit}
  int acc_cyc = 0, last_hs_cyc = 0, hs_idx = 0;
  logic hold_pend = 1'b0;
  logic [2:0] held = '0, e_mon = '0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected digit per handshake; checks hold under stall.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend && digit_valid_o)
        check("hold", {digit_last_o, digit_o}, held);
      hold_pend = 1'b0;
      if (digit_valid_o && digit_ready_i) begin
        if (q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_digit: got %0h expected none", {digit_last_o, digit_o});
        end else begin
          e_mon = q.pop_front();
          check($sformatf("digit%0d", hs_idx), {digit_last_o, digit_o}, e_mon);
          $display("digit %0d = %0d last=%0b", hs_idx, digit_o, digit_last_o);
          hs_idx++;
          if (e_mon[2]) last_hs_cyc = cyc + 1;
        end
      end else if (digit_valid_o) begin
        hold_pend = 1'b1;
        held = {digit_last_o, digit_o};
      end
    end
  end

  task automatic push_exp(input logic [31:0] prod, input int neff);
    for (int k = 0; k < 2*neff; k++)
      q.push_back({(k == 2*neff-1) ? 1'b1 : 1'b0, prod[2*k +: 2]});
  endtask

  task automatic wait_ready();
    int t = 0;
    @(negedge clk);
    while (!ready_o && t < 300) begin @(negedge clk); t++; end
    if (!ready_o) begin
      n_cmp++; n_err++;
      $display("FAIL wait_ready: got ready_o=0 expected 1 within 300 cycles");
    end
  endtask

  task automatic wait_done();
    int t = 0;
    @(negedge clk);
    while (!(q.size() == 0 && ready_o) && t < 400) begin @(negedge clk); t++; end
    if (!(q.size() == 0 && ready_o)) begin
      n_cmp++; n_err++;
      $display("FAIL wait_done: got %0d pending expected 0", q.size());
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_ready"}, ready_o, 1);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_valid"}, digit_valid_o, 0);
    check({tag, "_digit"}, digit_o, 0);
    check({tag, "_last"}, digit_last_o, 0);
  endtask

  task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] nd, input logic sgn,
                          input logic [31:0] prod, input int neff);
    wait_ready();
    a_i = a; b_i = b; n_digits_i = nd; signed_i = sgn; valid_i = 1'b1;
    push_exp(prod, neff);
    @(posedge clk); #1;
    valid_i = 1'b0;
    acc_cyc = cyc;
    hs_idx = 0;
  endtask

  task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] nd, input logic sgn, input logic [31:0] prod,
                        input int neff, input int exp_lat, input int st_start, input int st_len);
    $display("op %s: a=%0h b=%0h n=%0d s=%0b exp=%0h", name, a, b, nd, sgn, prod);
    start_op(a, b, nd, sgn, prod, neff);
    if (st_len > 0) begin
      repeat (st_start) @(posedge clk);
      #1 digit_ready_i = 1'b0;
      repeat (st_len) @(posedge clk);
      #1 digit_ready_i = 1'b1;
    end
    wait_done();
    check({name, "_latency"}, last_hs_cyc - acc_cyc, exp_lat);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1 check_reset_outs("por");
    @(negedge clk) rst_n = 1'b1;

    run_op("u2x2", 16'h000B, 16'h000D, 4'd2, 1'b0, 32'h0000008F, 2, 8, 0, 0);
    run_op("s2x2", 16'h000F, 16'h0003, 4'd2, 1'b1, 32'h000000FD, 2, 8, 0, 0);
    run_op("u8x8", 16'hFFFF, 16'hFFFF, 4'd8, 1'b0, 32'hFFFE0001, 8, 80, 0, 0);
    run_op("s0",   16'h8000, 16'h8000, 4'd0, 1'b1, 32'h40000000, 8, 80, 0, 0);
    // Stall while digit 1 is pending (valid from edge T4 after accept).
    run_op("bp",   16'h000B, 16'h000D, 4'd2, 1'b0, 32'h0000008F, 2, 13, 4, 5);

    // Reset during MAC of column 2 of a 4-digit operation.
    $display("op midrst: a=1234 b=5678 n=4");
    start_op(16'h1234, 16'h5678, 4'd4, 1'b0, 32'h06260060, 4);
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outs("midrst");
    check("midrst_digits_before", hs_idx, 2);
    q.delete();
    @(negedge clk) rst_n = 1'b1;
    run_op("s1", 16'h0002, 16'h0001, 4'd1, 1'b1, 32'h0000000E, 1, 3, 0, 0);

    // valid_i held high with changing operands while busy.
    $display("op proto: a=B b=D n=2 then a=3 b=3");
    wait_ready();
    a_i = 16'h000B; b_i = 16'h000D; n_digits_i = 4'd2; signed_i = 1'b0; valid_i = 1'b1;
    push_exp(32'h0000008F, 2);
    @(posedge clk); #1;
    acc_cyc = cyc; hs_idx = 0;
    t = 0;
    while (t < 300) begin
      @(negedge clk);
      if (!busy_o) break;
      check("proto_ready_low", ready_o, 0);
      a_i = 16'($urandom); b_i = 16'($urandom);
      n_digits_i = 4'($urandom); signed_i = 1'($urandom);
      t++;
    end
    check("proto_latency", last_hs_cyc - acc_cyc, 8);
    check("proto_drained", q.size(), 0);
    check("proto_ready_up", ready_o, 1);
    a_i = 16'h0003; b_i = 16'h0003; n_digits_i = 4'd2; signed_i = 1'b0;
    push_exp(32'h00000009, 2);
    @(posedge clk); #1;
    valid_i = 1'b0;
    acc_cyc = cyc; hs_idx = 0;
    wait_done();
    check("proto2_latency", last_hs_cyc - acc_cyc, 8);
    check("final_queue", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
